// File: rtl/mxn_pkg.sv
// Shared types and constants for the registered N:1 multiplexer cells.
package mxn_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  localparam int CW = 8;

  // Select width for an n-input mux; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mxn_sel.sv
// Pure combinational N:1 multiplexer of W-bit lanes; an out-of-range select yields zero.
module mxn_sel
  import mxn_pkg::*;
#(
  parameter int W  = 1,
  parameter int N  = 3,
  parameter int SW = sel_width(N)
) (
  input  logic [N*W-1:0] i,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y
);

  logic [W-1:0] lanes [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lanes[gi] = i[gi*W +: W];
    end
  endgenerate

  always_comb begin
    y = '0;
    for (int n = 0; n < N; n++) begin
      if (sel == SW'(n)) y = lanes[n];
    end
  end

endmodule

// File: rtl/mxn_reg.sv
// Registered N:1 mux with a valid/ready select handshake and a blanking window
// inserted on every select change.
module mxn_reg
  import mxn_pkg::*;
#(
  parameter int             W      = 1,
  parameter int             N      = 3,
  parameter int             SW     = sel_width(N),
  parameter int             SETTLE = 2,
  parameter logic [W-1:0]   IDLE   = '0
) (
  input  logic           ck,
  input  logic           rst,
  input  logic [N*W-1:0] i,
  input  logic [SW-1:0]  cmd,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  output logic [W-1:0]   q,
  output logic           q_vld,
  output logic [SW-1:0]  cur,
  output logic           err
);

  localparam logic [SW:0]   N_LIM     = (SW+1)'(N);
  localparam logic [CW-1:0] CNT_START = CW'(SETTLE - 1);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [SW-1:0] cur_reg;
  logic [W-1:0]  q_reg;
  logic          q_vld_reg;
  logic          err_reg;

  logic          hs;
  logic          in_range;
  logic          switch_now;
  logic [SW-1:0] mux_sel;
  logic [W-1:0]  mux_y;

  assign cmd_rdy    = (state_reg == RUN) & ~rst;
  assign hs         = cmd_vld & cmd_rdy;
  assign in_range   = ({1'b0, cmd} < N_LIM);
  assign switch_now = hs & in_range;
  // With SETTLE=0 the new lane must appear on the very edge that accepts it.
  assign mux_sel    = switch_now ? cmd : cur_reg;

  mxn_sel #(
    .W  (W),
    .N  (N),
    .SW (SW)
  ) u_sel (
    .i   (i),
    .sel (mux_sel),
    .y   (mux_y)
  );

  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      cur_reg   <= '0;
      q_reg     <= IDLE;
      q_vld_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          q_reg     <= mux_y;
          q_vld_reg <= 1'b1;
          if (hs) begin
            if (!in_range) begin
              err_reg <= 1'b1;
            end else if (cmd != cur_reg) begin
              cur_reg <= cmd;
              if (SETTLE > 0) begin
                cnt_reg   <= CNT_START;
                state_reg <= BLANK;
                q_reg     <= IDLE;
                q_vld_reg <= 1'b0;
              end
            end
          end
        end
        BLANK: begin
          q_reg     <= IDLE;
          q_vld_reg <= 1'b0;
          if (cnt_reg == '0) state_reg <= RUN;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign q     = q_reg;
  assign q_vld = q_vld_reg;
  assign cur   = cur_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_mxn_reg.sv
// Bench for mxn_reg: two instances (SETTLE=2 and SETTLE=0) driven in parallel and
// compared every cycle against a cycle-count reference model.
module tb_mxn_reg;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int SW = 2;

  logic           ck = 1'b0;
  logic           rst;
  logic [N*W-1:0] i;
  logic [SW-1:0]  cmd;
  logic           cmd_vld;

  logic          rdy_a, rdy_b;
  logic [W-1:0]  q_a, q_b;
  logic          v_a, v_b;
  logic [SW-1:0] cur_a, cur_b;
  logic          err_a, err_b;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, index 0 = SETTLE 2, index 1 = SETTLE 0
  int           m_settle [2] = '{2, 0};
  logic [W-1:0] m_idle   [2] = '{4'h0, 4'h5};
  int           m_cur    [2];
  int           m_busy   [2];
  logic [W-1:0] m_q      [2];
  logic         m_v      [2];
  logic         m_err    [2];

  always #5 ck = ~ck;

  mxn_reg #(.W(W), .N(N), .SW(SW), .SETTLE(2), .IDLE(4'h0)) dut_a (
    .ck(ck), .rst(rst), .i(i), .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(rdy_a),
    .q(q_a), .q_vld(v_a), .cur(cur_a), .err(err_a)
  );

  mxn_reg #(.W(W), .N(N), .SW(SW), .SETTLE(0), .IDLE(4'h5)) dut_b (
    .ck(ck), .rst(rst), .i(i), .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(rdy_b),
    .q(q_b), .q_vld(v_b), .cur(cur_b), .err(err_b)
  );

  function automatic logic [W-1:0] lane(input int n);
    return i[n*W +: W];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour for instance k.
  task automatic model_edge(input int k);
    bit hs;
    bit blank;
    hs    = cmd_vld && !rst && (m_busy[k] == 0);
    blank = 1'b0;
    m_err[k] = 1'b0;
    if (rst) begin
      m_cur[k]  = 0;
      m_busy[k] = 0;
      m_q[k]    = m_idle[k];
      m_v[k]    = 1'b0;
    end else if (m_busy[k] > 0) begin
      m_busy[k]--;
      m_q[k] = m_idle[k];
      m_v[k] = 1'b0;
    end else begin
      if (hs && int'(cmd) >= N) begin
        m_err[k] = 1'b1;
      end else if (hs && int'(cmd) != m_cur[k]) begin
        m_cur[k] = int'(cmd);
        if (m_settle[k] > 0) begin
          m_busy[k] = m_settle[k];
          blank     = 1'b1;
        end
      end
      m_q[k] = blank ? m_idle[k] : lane(m_cur[k]);
      m_v[k] = !blank;
    end
  endtask

  task automatic step();
    #1;
    check("rdy_a", 32'(rdy_a), 32'(!rst && m_busy[0] == 0));
    check("rdy_b", 32'(rdy_b), 32'(!rst && m_busy[1] == 0));
    @(posedge ck);
    model_edge(0);
    model_edge(1);
    #1;
    check("q_a",   32'(q_a),   32'(m_q[0]));
    check("vld_a", 32'(v_a),   32'(m_v[0]));
    check("cur_a", 32'(cur_a), 32'(m_cur[0]));
    check("err_a", 32'(err_a), 32'(m_err[0]));
    check("q_b",   32'(q_b),   32'(m_q[1]));
    check("vld_b", 32'(v_b),   32'(m_v[1]));
    check("cur_b", 32'(cur_b), 32'(m_cur[1]));
    check("err_b", 32'(err_b), 32'(m_err[1]));
    $display("t=%0t rst=%0b i=%h cmd=%0d vld=%0b | a: q=%h v=%0b cur=%0d err=%0b | b: q=%h v=%0b cur=%0d err=%0b",
             $time, rst, i, cmd, cmd_vld, q_a, v_a, cur_a, err_a, q_b, v_b, cur_b, err_b);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cur[k] = 0; m_busy[k] = 0; m_q[k] = m_idle[k]; m_v[k] = 1'b0; m_err[k] = 1'b0;
    end
    rst = 1'b1; i = {4'hC, 4'hB, 4'hA}; cmd = '0; cmd_vld = 1'b0;
    @(negedge ck);

    // Reset held two cycles
    step();
    step();
    check("rst_q", 32'(q_a), 32'h0);
    check("rst_vld", 32'(v_a), 32'h0);

    // Release
    rst = 1'b0;
    step();
    check("rel_q", 32'(q_a), 32'hA);
    check("rel_cur", 32'(cur_a), 32'h0);

    // Switch to 2 with blanking on instance a, immediate on b
    cmd = 2'd2; cmd_vld = 1'b1;
    step();
    check("sw_cur", 32'(cur_a), 32'h2);
    check("sw_b_q", 32'(q_b), 32'hC);
    cmd_vld = 1'b0;
    step();
    step();
    step();
    check("sw_q_live", 32'(q_a), 32'hC);

    // Same select keeps data flowing
    cmd = 2'd2; cmd_vld = 1'b1;
    for (int n = 0; n < 3; n++) begin
      i = {4'(n + 3), 4'(n + 2), 4'(n + 1)};
      step();
    end

    // Out-of-range select
    cmd = 2'd3;
    step();
    check("oor_err", 32'(err_a), 32'h1);
    cmd_vld = 1'b0;
    step();
    check("oor_err_clr", 32'(err_a), 32'h0);

    // Switch to 1: immediate on b, blanked on a
    i = {4'h9, 4'h6, 4'h3};
    cmd = 2'd1; cmd_vld = 1'b1;
    step();
    check("s0_q", 32'(q_b), 32'h6);
    cmd_vld = 1'b0;
    step();
    step();
    step();

    // Reset during the second blanking cycle
    cmd = 2'd2; cmd_vld = 1'b1;
    step();
    cmd_vld = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("mid_cur", 32'(cur_a), 32'h0);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      i       = N*W'($urandom);
      cmd     = SW'($urandom_range(0, 3));
      cmd_vld = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 40) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mxn_reg.md
# mxn_reg

Parametrised N-input, W-bit registered multiplexer for the standard-cell library's datapath tier; the sequential successor of the fixed 3-input combinational mux cells. Selection changes arrive through a valid/ready command handshake, the output is registered, and every switch inserts a programmable blanking window during which the output is forced to an idle value and flagged invalid. Out-of-range selects are rejected with an error pulse.

## Interface
- W, default 1: data width per input.
- N, default 3: number of inputs, N ≥ 2.
- SW, default $clog2(N): select width.
- SETTLE, default 2: blanking cycles per switch, 0..255.
- IDLE, default 0: W-bit value driven on q while blanked or in reset.

- ck  in  1: clock, all state on rising edge.
- rst  in  1: reset, synchronous, active-high.
- i  in  N*W: packed inputs, input n at bits [n*W +: W].
- cmd  in  SW: requested select.
- cmd_vld  in  1: cmd valid.
- cmd_rdy  out  1: block accepts cmd this cycle.
- q  out  W: registered selected data.
- q_vld  out  1: q carries live data.
- cur  out  SW: active select.
- err  out  1: one-cycle pulse, out-of-range cmd rejected.

## Operation
- States: RUN, BLANK. 8-bit down-counter cnt.
- Reset (rst=1 at edge): state=RUN, cur=0, cnt=0, q=IDLE, q_vld=0, err=0. cmd_rdy forced 0 while rst=1.
- cmd_rdy = (state==RUN) & ~rst, combinational.
- RUN, no handshake: q<=i[cur], q_vld<=1.
- RUN, handshake (cmd_vld & cmd_rdy):
  - cmd ≥ N: err<=1, cur unchanged, q<=i[cur], q_vld<=1.
  - cmd == cur: accepted, no effect beyond normal RUN update.
  - cmd ≠ cur, SETTLE>0: cur<=cmd, cnt<=SETTLE-1, state<=BLANK, q<=IDLE, q_vld<=0.
  - cmd ≠ cur, SETTLE=0: cur<=cmd, q<=i[cmd], q_vld<=1; no BLANK.
- BLANK: q<=IDLE, q_vld<=0, cmd ignored; cnt==0 → state<=RUN, else cnt<=cnt-1.
- err low every cycle not listed above.
- rst mid-BLANK: immediate return to reset values; pending switch abandoned, cur=0.

## Timing
- Data latency: 1 cycle, i at edge t visible on q after edge t.
- Switch accepted at edge e: q_vld low after edges e..e+SETTLE (SETTLE+1 cycles); first q=i[new] after edge e+SETTLE+1. cur updates after edge e.
- cmd_rdy low for exactly SETTLE cycles after an accepted switch.
- After reset release: q_vld rises after first edge with rst=0.
- err pulse aligned to the cycle after the rejected handshake.
- No combinational path i→q; cmd_vld→cmd_rdy has no path (cmd_rdy depends only on state, rst).

## Structure
- Package mxn_pkg: state enum (RUN, BLANK), counter width constant CW=8, localparam helper for SW.
- Sub-module mxn_sel: pure combinational N:1, W-bit mux (i, sel → y), instantiated once with sel = switch ? cmd : cur; reusable by later cells.
- Top holds FSM, counter, output register, err register.

## Test plan
- Reset: W=4,N=3, rst high 2 cycles with i={4'hC,4'hB,4'hA} → q=IDLE=0, q_vld=0, cmd_rdy=0; release → q=4'hA, q_vld=1, cur=0 next cycle.
- Switch SETTLE=2: cmd=2 handshake at edge e → q_vld low 3 cycles, cmd_rdy low 2 cycles, q=4'hC after edge e+3, cur=2 after e.
- Same select: cmd=cur → no blanking, q_vld stays 1, q tracks i[cur] each cycle.
- Out-of-range: N=3, cmd=3 → err=1 one cycle, cur and q_vld unchanged.
- SETTLE=0: cmd=1 at edge e → q=i[1] after e, q_vld never drops.
- Reset mid-BLANK: rst asserted during second BLANK cycle → cur=0, q=IDLE, state RUN, cmd_rdy=1 after release.
